// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared types and constants for the LED ping-pong game controller.
//            Game state encoding, play-mode encodings and small state helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE   = 3'd1,
    MOVE_DN = 3'd2,
    MOVE_UP = 3'd3,
    P1_WIN  = 3'd4,
    P2_WIN  = 3'd5
  } state_t;

  localparam logic MODE_CPU = 1'b0;
  localparam logic MODE_2P  = 1'b1;

  // Ball is travelling along the track (step timer running)
  function automatic logic is_moving(input state_t s);
    return (s == MOVE_DN) || (s == MOVE_UP);
  endfunction

  // Game is over and the display is flashing
  function automatic logic is_win(input state_t s);
    return (s == P1_WIN) || (s == P2_WIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : pong_step_timer
// Purpose  : Ball step timer. Holds the current step period, shortens it by
//            one every SPEEDUP_HITS returns (never below 1) and emits a tick
//            once per period.
// Ports    : slw_clk  - game clock
//            Rst      - asynchronous active-high reset
//            restart  - clear the cycle counter (state entry / idle)
//            hit      - one successful return (speed-up accounting)
//            reload   - restore the serve period and clear the return count
//            tick     - step strobe, high in the last cycle of each period
//            period   - current step period in slw_clk cycles
// Revision : 1.0 - initial release
// ============================================================================
module pong_step_timer
  import pong_pkg::*;
#(
  parameter int START_PERIOD = 4,
  parameter int SPEEDUP_HITS = 3
) (
  input  logic                              slw_clk,
  input  logic                              Rst,
  input  logic                              restart,
  input  logic                              hit,
  input  logic                              reload,
  output logic                              tick,
  output logic [$clog2(START_PERIOD+1)-1:0] period
);

  localparam int PER_W = $clog2(START_PERIOD + 1);
  localparam int HIT_W = $clog2(SPEEDUP_HITS + 1);

  localparam logic [PER_W-1:0] C_START    = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] C_PER_MIN  = PER_W'(1);
  localparam logic [HIT_W-1:0] C_HIT_LAST = HIT_W'(SPEEDUP_HITS - 1);

  logic [PER_W-1:0] r_cnt;
  logic [HIT_W-1:0] r_hit_cnt;

  // Tick depends only on registered state so the FSM may feed restart
  // back from its next-state logic without forming a combinational loop.
  assign tick = (r_cnt == (period - 1'b1));

  always_ff @(posedge slw_clk or posedge Rst) begin
    if (Rst) begin
      r_cnt     <= '0;
      r_hit_cnt <= '0;
      period    <= C_START;
    end else begin
      if (restart || tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (reload) begin
        r_hit_cnt <= '0;
        period    <= C_START;
      end else if (hit) begin
        if (r_hit_cnt == C_HIT_LAST) begin
          r_hit_cnt <= '0;
          if (period > C_PER_MIN) begin
            period <= period - 1'b1;
          end
        end else begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : pong_ctrl_param
// Purpose  : Parametrised LED ping-pong game controller (vs-CPU and
//            two-player), with rising-edge bat detection, end-LED hit window,
//            rally speed-up, scoring and win flashing.
// Ports    : slw_clk     - game clock
//            Rst         - asynchronous active-high reset
//            start_btn   - start / serve button (level)
//            p1_btn      - player-1 bat, MSB end (level)
//            p2_btn      - player-2 bat, LSB end (level, unused vs CPU)
//            abort       - synchronous return to IDLE
//            mode        - 0 vs CPU, 1 two-player; sampled at game start
//            leds        - ball position / loss flash
//            score_p1/2  - scores
//            p1_win/p2_win - game-over flags
//            colour_leds - flash on a player-1 win
// Revision : 1.0 - initial release
// ============================================================================
module pong_ctrl_param
  import pong_pkg::*;
#(
  parameter int N_LEDS       = 4,
  parameter int WIN_SCORE    = 10,
  parameter int START_PERIOD = 4,
  parameter int SPEEDUP_HITS = 3
) (
  input  logic                           slw_clk,
  input  logic                           Rst,
  input  logic                           start_btn,
  input  logic                           p1_btn,
  input  logic                           p2_btn,
  input  logic                           abort,
  input  logic                           mode,
  output logic [N_LEDS-1:0]              leds,
  output logic [$clog2(WIN_SCORE+1)-1:0] score_p1,
  output logic [$clog2(WIN_SCORE+1)-1:0] score_p2,
  output logic                           p1_win,
  output logic                           p2_win,
  output logic [2:0]                     colour_leds
);

  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int POS_W   = $clog2(N_LEDS);
  localparam int PER_W   = $clog2(START_PERIOD + 1);

  localparam logic [POS_W-1:0]   C_POS_MAX = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]   C_POS_ONE = POS_W'(1);
  localparam logic [SCORE_W-1:0] C_WIN     = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic [POS_W-1:0]   r_pos;
  logic               r_mode;
  logic               r_fl;
  logic               r_prev_start, r_prev_p1, r_prev_p2;
  logic               r_edge_start, r_edge_p1, r_edge_p2;
  logic               r_pend_p1, r_pend_p2;

  state_t             w_nst;
  logic [POS_W-1:0]   w_npos;
  logic               w_nmode;
  logic               w_nfl;
  logic [SCORE_W-1:0] w_ns1, w_ns2;
  logic [N_LEDS-1:0]  w_nleds;
  logic               w_hit, w_reload, w_restart;
  logic               w_tick;
  logic [PER_W-1:0]   w_period;
  logic               w_p1_hit, w_p2_hit;
  logic               w_p1_window, w_p2_window;

  pong_step_timer #(
    .START_PERIOD (START_PERIOD),
    .SPEEDUP_HITS (SPEEDUP_HITS)
  ) u_timer (
    .slw_clk (slw_clk),
    .Rst     (Rst),
    .restart (w_restart),
    .hit     (w_hit),
    .reload  (w_reload),
    .tick    (w_tick),
    .period  (w_period)
  );

  // The period register must always hold a usable, non-zero step length.
  a_period_range : assert property (@(posedge slw_clk) disable iff (Rst)
    (w_period != '0) && (w_period <= PER_W'(START_PERIOD)));

  // A bat edge counts if it was latched earlier in the dwell or arrives in
  // the very cycle the end is resolved.
  assign w_p1_hit = r_pend_p1 | r_edge_p1;
  assign w_p2_hit = r_pend_p2 | r_edge_p2;

  // Hit windows: ball on the player's end LED, still approaching it, and
  // the end not being resolved this cycle.
  assign w_p1_window = (r_state == MOVE_UP) && (r_pos == C_POS_MAX) && !w_tick && !abort;
  assign w_p2_window = (r_state == MOVE_DN) && (r_pos == '0) && (r_mode == MODE_2P)
                       && !w_tick && !abort;

  always_comb begin
    w_nst    = r_state;
    w_npos   = r_pos;
    w_nmode  = r_mode;
    w_ns1    = score_p1;
    w_ns2    = score_p2;
    w_hit    = 1'b0;
    w_reload = 1'b0;

    case (r_state)
      IDLE: begin
        w_ns1    = '0;
        w_ns2    = '0;
        w_npos   = C_POS_MAX;
        w_reload = 1'b1;
        if (r_edge_start) begin
          w_nmode = mode;
          w_nst   = MOVE_DN;
        end
      end

      SERVE: begin
        if ((r_pos == C_POS_MAX) && r_edge_p1) begin
          w_nst = MOVE_DN;
        end else if ((r_pos == '0) && r_edge_p2) begin
          w_nst = MOVE_UP;
        end
      end

      MOVE_DN: begin
        if (w_tick) begin
          if (r_pos != '0) begin
            w_npos = r_pos - 1'b1;
          end else if (r_mode == MODE_CPU) begin
            // CPU always returns; not counted as a rally hit
            w_npos = C_POS_ONE;
            w_nst  = MOVE_UP;
          end else if (w_p2_hit) begin
            w_npos = C_POS_ONE;
            w_nst  = MOVE_UP;
            w_hit  = 1'b1;
          end else begin
            w_ns1    = score_p1 + 1'b1;
            w_reload = 1'b1;
            if (w_ns1 == C_WIN) begin
              w_nst = P1_WIN;
            end else begin
              w_nst  = SERVE;
              w_npos = '0;
            end
          end
        end
      end

      MOVE_UP: begin
        if (w_tick) begin
          if (r_pos != C_POS_MAX) begin
            w_npos = r_pos + 1'b1;
          end else if (w_p1_hit) begin
            if (r_mode == MODE_CPU) begin
              w_ns1 = score_p1 + 1'b1;
            end
            if ((r_mode == MODE_CPU) && (w_ns1 == C_WIN)) begin
              w_nst = P1_WIN;
            end else begin
              w_npos = C_POS_MAX - 1'b1;
              w_nst  = MOVE_DN;
              w_hit  = 1'b1;
            end
          end else if (r_mode == MODE_CPU) begin
            w_nst = P2_WIN;
          end else begin
            w_ns2    = score_p2 + 1'b1;
            w_reload = 1'b1;
            if (w_ns2 == C_WIN) begin
              w_nst = P2_WIN;
            end else begin
              w_nst  = SERVE;
              w_npos = C_POS_MAX;
            end
          end
        end
      end

      default: begin
        // P1_WIN / P2_WIN hold until abort or reset
      end
    endcase

    if (abort) begin
      w_nst    = IDLE;
      w_npos   = C_POS_MAX;
      w_ns1    = '0;
      w_ns2    = '0;
      w_hit    = 1'b0;
      w_reload = 1'b1;
    end

    // Flash starts dark on win entry and then toggles every cycle
    w_nfl     = (is_win(r_state) && (w_nst == r_state)) ? ~r_fl : 1'b0;
    w_restart = (w_nst != r_state) || !is_moving(w_nst);

    case (w_nst)
      P1_WIN:  w_nleds = '0;
      P2_WIN:  w_nleds = {N_LEDS{w_nfl}};
      default: w_nleds = N_LEDS'(1) << w_npos;
    endcase
  end

  always_ff @(posedge slw_clk or posedge Rst) begin
    if (Rst) begin
      r_prev_start <= 1'b0;
      r_prev_p1    <= 1'b0;
      r_prev_p2    <= 1'b0;
      r_edge_start <= 1'b0;
      r_edge_p1    <= 1'b0;
      r_edge_p2    <= 1'b0;
    end else begin
      r_prev_start <= start_btn;
      r_prev_p1    <= p1_btn;
      r_prev_p2    <= p2_btn;
      r_edge_start <= start_btn & ~r_prev_start;
      r_edge_p1    <= p1_btn & ~r_prev_p1;
      r_edge_p2    <= p2_btn & ~r_prev_p2;
    end
  end

  always_ff @(posedge slw_clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_pos       <= C_POS_MAX;
      r_mode      <= MODE_CPU;
      r_fl        <= 1'b0;
      r_pend_p1   <= 1'b0;
      r_pend_p2   <= 1'b0;
      score_p1    <= '0;
      score_p2    <= '0;
      p1_win      <= 1'b0;
      p2_win      <= 1'b0;
      leds        <= '0;
      colour_leds <= 3'b000;
    end else begin
      r_state     <= w_nst;
      r_pos       <= w_npos;
      r_mode      <= w_nmode;
      r_fl        <= w_nfl;
      r_pend_p1   <= w_p1_window & (r_pend_p1 | r_edge_p1);
      r_pend_p2   <= w_p2_window & (r_pend_p2 | r_edge_p2);
      score_p1    <= w_ns1;
      score_p2    <= w_ns2;
      p1_win      <= (w_nst == P1_WIN);
      p2_win      <= (w_nst == P2_WIN);
      leds        <= w_nleds;
      colour_leds <= (w_nst == P1_WIN) ? {3{w_nfl}} : 3'b000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_ctrl_param
// Purpose  : Self-checking bench for pong_ctrl_param. Random bat/start/abort
//            activity is scored against a behavioural game model (ball
//            position + direction + dwell age) every cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_ctrl_param;

  localparam int N   = 4;
  localparam int WIN = 10;
  localparam int SP  = 4;
  localparam int SH  = 3;

  logic       slw_clk = 1'b0;
  logic       Rst = 1'b1;
  logic       start_btn = 1'b0, p1_btn = 1'b0, p2_btn = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [N-1:0] leds;
  logic [3:0] score_p1, score_p2;
  logic       p1_win, p2_win;
  logic [2:0] colour_leds;

  int n_total = 0;
  int n_bad   = 0;

  // Game model: phase 0 idle, 1 serve, 2 play, 3 p1 won, 4 p2 won
  int m_ph, m_ball, m_dir, m_age, m_per, m_rets, m_s1, m_s2;
  bit m_mm, m_fl, m_arm1, m_arm2;
  bit m_lv_s, m_lv_1, m_lv_2, m_ev_s, m_ev_1, m_ev_2;
  int e_leds, e_col;

  pong_ctrl_param #(
    .N_LEDS(N), .WIN_SCORE(WIN), .START_PERIOD(SP), .SPEEDUP_HITS(SH)
  ) dut (
    .slw_clk(slw_clk), .Rst(Rst), .start_btn(start_btn), .p1_btn(p1_btn),
    .p2_btn(p2_btn), .abort(abort), .mode(mode), .leds(leds),
    .score_p1(score_p1), .score_p2(score_p2), .p1_win(p1_win),
    .p2_win(p2_win), .colour_leds(colour_leds)
  );

  always #5 slw_clk = ~slw_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_ball = N - 1; m_dir = -1; m_age = 0; m_per = SP; m_rets = 0;
    m_s1 = 0; m_s2 = 0; m_mm = 0; m_fl = 0; m_arm1 = 0; m_arm2 = 0;
    m_lv_s = 0; m_lv_1 = 0; m_lv_2 = 0; m_ev_s = 0; m_ev_1 = 0; m_ev_2 = 0;
    e_leds = 0; e_col = 0;
  endtask

  // One rising clock edge of the game, using the inputs currently driven
  task automatic model_edge();
    int nph = m_ph, nball = m_ball, ndir = m_dir, nage = m_age;
    int nper = m_per, nrets = m_rets, ns1 = m_s1, ns2 = m_s2;
    bit nmm = m_mm, nfl, narm1, narm2, tk, ret;
    tk  = (m_age + 1 >= m_per);
    ret = 0;
    case (m_ph)
      0: begin
        ns1 = 0; ns2 = 0; nball = N - 1; nper = SP; nrets = 0;
        if (m_ev_s) begin nph = 2; ndir = -1; nage = 0; nmm = mode; end
      end
      1: begin
        if (m_ball == N - 1 && m_ev_1) begin nph = 2; ndir = -1; nage = 0; end
        else if (m_ball == 0 && m_ev_2) begin nph = 2; ndir = 1; nage = 0; end
      end
      2: begin
        if (!tk) nage = m_age + 1;
        else if (m_ball + m_dir >= 0 && m_ball + m_dir < N) begin
          nball = m_ball + m_dir; nage = 0;
        end else if (m_dir > 0) begin
          if (m_arm1 || m_ev_1) begin
            if (!m_mm) ns1 = m_s1 + 1;
            if (!m_mm && ns1 == WIN) nph = 3;
            else ret = 1;
          end else if (!m_mm) nph = 4;
          else begin
            ns2 = m_s2 + 1;
            if (ns2 == WIN) nph = 4;
            else begin nph = 1; nball = N - 1; nper = SP; nrets = 0; end
          end
        end else begin
          if (!m_mm) begin nball = 1; ndir = 1; nage = 0; end
          else if (m_arm2 || m_ev_2) ret = 1;
          else begin
            ns1 = m_s1 + 1;
            if (ns1 == WIN) nph = 3;
            else begin nph = 1; nball = 0; nper = SP; nrets = 0; end
          end
        end
        if (ret) begin
          nball = m_ball - m_dir; ndir = -m_dir; nage = 0; nrets = m_rets + 1;
          if (nrets % SH == 0 && m_per > 1) nper = m_per - 1;
        end
      end
      default: ;
    endcase
    narm1 = (m_ph == 2 && m_dir > 0 && m_ball == N - 1 && !tk) && (m_arm1 || m_ev_1);
    narm2 = (m_ph == 2 && m_mm && m_dir < 0 && m_ball == 0 && !tk) && (m_arm2 || m_ev_2);
    nfl   = (m_ph >= 3 && nph == m_ph) ? !m_fl : 1'b0;
    if (abort) begin
      nph = 0; nball = N - 1; ns1 = 0; ns2 = 0; nper = SP; nrets = 0;
      narm1 = 0; narm2 = 0; nfl = 0;
    end
    m_ev_s = start_btn && !m_lv_s; m_lv_s = start_btn;
    m_ev_1 = p1_btn && !m_lv_1;    m_lv_1 = p1_btn;
    m_ev_2 = p2_btn && !m_lv_2;    m_lv_2 = p2_btn;
    m_ph = nph; m_ball = nball; m_dir = ndir; m_age = nage; m_per = nper;
    m_rets = nrets; m_s1 = ns1; m_s2 = ns2; m_mm = nmm; m_fl = nfl;
    m_arm1 = narm1; m_arm2 = narm2;
    if (m_ph <= 2)                e_leds = 1 << m_ball;
    else if (m_ph == 4 && m_fl)   e_leds = (1 << N) - 1;
    else                          e_leds = 0;
    e_col = (m_ph == 3 && m_fl) ? 7 : 0;
  endtask

  task automatic check_outputs();
    chk("leds", leds, e_leds);
    chk("score_p1", score_p1, m_s1);
    chk("score_p2", score_p2, m_s2);
    chk("p1_win", p1_win, m_ph == 3);
    chk("p2_win", p2_win, m_ph == 4);
    chk("colour_leds", colour_leds, e_col);
  endtask

  task automatic cyc();
    @(posedge slw_clk);
    model_edge();
    @(negedge slw_clk);
    check_outputs();
  endtask

  // Bat policy: sk = per-cycle percent chance to swing while the ball is
  // about to sit on (or sits on) that player's end LED; noise = stray edges.
  task automatic drive(input int sk1, input int sk2, input bit noise);
    bit w1, w2;
    w1 = 0; w2 = 0;
    start_btn = (m_ph == 0) && !start_btn && ($urandom_range(0, 3) == 0);
    if (m_ph == 1 && m_ball == N - 1 && $urandom_range(0, 2) == 0) w1 = 1;
    if (m_ph == 1 && m_ball == 0 && $urandom_range(0, 2) == 0) w2 = 1;
    if (m_ph == 2 && m_dir > 0 &&
        ((m_ball == N - 1 && m_age < m_per - 1) || (m_ball == N - 2 && m_age == m_per - 1)) &&
        $urandom_range(1, 100) <= sk1) w1 = 1;
    if (m_ph == 2 && m_dir < 0 &&
        ((m_ball == 0 && m_age < m_per - 1) || (m_ball == 1 && m_age == m_per - 1)) &&
        $urandom_range(1, 100) <= sk2) w2 = 1;
    if (noise && $urandom_range(0, 24) == 0) w1 = 1;
    if (noise && $urandom_range(0, 24) == 0) w2 = 1;
    p1_btn = w1 && !p1_btn;
    p2_btn = w2 && !p2_btn;
  endtask

  task automatic pulse_abort();
    start_btn = 0; p1_btn = 0; p2_btn = 0; abort = 1;
    cyc();
    abort = 0;
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge slw_clk);
    @(negedge slw_clk);
    check_outputs();
    Rst = 0;
    cyc();
    chk("idle_leds", leds, 8);

    // Mode 0, player 1 never misses: runs to a player-1 win
    mode = 0;
    for (int i = 0; i < 6000 && m_ph != 3; i++) begin drive(100, 100, 0); cyc(); end
    repeat (6) begin drive(100, 100, 0); cyc(); end
    chk("e1_p1_win", p1_win, 1);
    chk("e1_score", score_p1, WIN);
    pulse_abort();
    chk("e1_abort_leds", leds, 8);

    // Mode 0, player 1 never swings: CPU wins and leds flash
    for (int i = 0; i < 2000 && m_ph != 4; i++) begin drive(0, 50, 0); cyc(); end
    repeat (6) begin drive(0, 50, 0); cyc(); end
    chk("e2_p2_win", p2_win, 1);
    pulse_abort();
    chk("e2_abort_leds", leds, 8);
    chk("e2_abort_score", score_p1, 0);

    // Mixed random play in both modes with stray edges and aborts
    for (int i = 0; i < 4000; i++) begin
      mode  = 1'($urandom_range(0, 1));
      abort = ((m_ph >= 3) && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 599) == 0);
      drive(70, 70, 1);
      cyc();
    end
    abort = 0;

    // Asynchronous reset in the middle of a rally
    if (m_ph != 0) pulse_abort();
    mode = 0;
    for (int i = 0; i < 400 && !(m_ph == 2 && m_ball == 1); i++) begin drive(100, 0, 0); cyc(); end
    chk("e4_mid_rally_leds", leds, 2);
    start_btn = 0; p1_btn = 0; p2_btn = 0;
    @(posedge slw_clk);
    model_edge();
    #3 Rst = 1;
    #1;
    model_reset();
    chk("rst_leds", leds, 0);
    chk("rst_score_p1", score_p1, 0);
    chk("rst_score_p2", score_p2, 0);
    chk("rst_flags", {p1_win, p2_win, colour_leds}, 0);
    @(negedge slw_clk);
    @(negedge slw_clk);
    Rst = 0;
    cyc();
    chk("rst_idle_leds", leds, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_ctrl_param.md
# pong_ctrl_param

Parametrised second-generation game controller for the LED ping-pong game, running on the slow game clock. It moves a one-hot ball across `N_LEDS` LEDs and scores hits or points up to `WIN_SCORE`. It supports a vs-CPU mode and a two-player mode, and speeds the ball up as the rally progresses. It sits between the debounced button inputs and the LED/score display drivers.

## Interface
Parameters:
- `N_LEDS`, 4: ball track length; must be ≥ 2.
- `WIN_SCORE`, 10: score that ends the game; must be ≥ 1.
- `START_PERIOD`, 4: slw_clk cycles per ball step at serve; must be ≥ 1.
- `SPEEDUP_HITS`, 3: successful returns between period decrements; must be ≥ 1.

Ports:
- `slw_clk`  in  1  game clock.
- `Rst`  in  1  reset, asynchronous, active-high.
- `start_btn`  in  1  start or serve button; level, synchronous to slw_clk.
- `p1_btn`  in  1  player-1 bat (MSB end); level.
- `p2_btn`  in  1  player-2 bat (LSB end); level; ignored in mode 0.
- `abort`  in  1  synchronous soft reset to IDLE.
- `mode`  in  1  0 = vs CPU, 1 = two-player; latched on game start.
- `leds`  out  N_LEDS  ball position / flash pattern.
- `score_p1`, `score_p2`  out  SCORE_W each  scores; SCORE_W = $clog2(WIN_SCORE+1).
- `p1_win`, `p2_win`  out  1  game-over flags (`p2_win` = CPU win in mode 0).
- `colour_leds`  out  3  flash on a player-1 win.

## Operation
- All outputs registered. Reset values: all zero; state IDLE; `pos` = N_LEDS-1; `period` = START_PERIOD.
- Button hits use rising edges only: the previous level is registered per button, and the prev registers reset to 0.
- `leds` = 1 << `pos` in IDLE, SERVE, MOVE_DN and MOVE_UP.
- States:
  - IDLE: scores, flags and colour_leds are cleared. `pos` = N-1 and `period` = START_PERIOD. A `start_btn` edge latches `mode` and goes to MOVE_DN.
  - MOVE_DN: a step tick decrements `pos`. When `pos` = 0 at a tick, the LSB end is resolved:
    - mode 0: auto-return; `pos` goes to 1 and the state goes to MOVE_UP.
    - mode 1: a latched P2 hit returns the ball. Otherwise P1 scores a point.
  - MOVE_UP: a step tick increments `pos`. When `pos` = N-1 at a tick, P1 hit resolution:
    - A latched hit returns the ball: `pos` goes to N-2 and the state goes to MOVE_DN.
    - mode 0: a hit increments `score_p1`. A miss goes to P2_WIN.
    - mode 1: a miss gives P2 a point.
  - Point scored (mode 1 only): the scorer's score increments. The state goes to SERVE with the ball at the loser's end, and `period` is restored to START_PERIOD.
  - SERVE: waits for the server's button edge. The server is P1 at N-1 (which then moves down) or P2 at 0 (which then moves up).
  - P1_WIN / P2_WIN: the win flag is held at 1 and the flash toggle `fl` inverts every cycle.
    - P1_WIN: `colour_leds` = {3{fl}}.
    - P2_WIN: `leds` = {N{fl}}.
    - The state is left only via `abort` or `Rst`.
- Hit window:
  - A button edge is latched into `hit_pend_x` only while the ball sits on that player's end LED.
  - Edges at any other time are ignored.
  - `hit_pend_x` is cleared when the end is resolved.
- Speed-up: `hit_cnt` increments on each return (auto-returns excluded). When it reaches SPEEDUP_HITS, it wraps to 0 and `period` decrements, saturating at 1.
- Win check happens in the resolving cycle. If the incremented score equals WIN_SCORE, the next state is the win state instead of a bounce or serve.
- `abort` takes precedence over every transition. It goes to IDLE on the next edge, and IDLE clears everything.

## Timing
- The step tick is generated by a period counter. It fires when the counter reaches `period`-1; the counter then clears. It also clears on every state entry.
- With no change in `period`, the ball moves exactly one LED per `period` cycles.
- End resolution happens on the tick that would move the ball off the end LED. The dwell on the end LED is therefore `period` cycles.
- The ball leaves IDLE/SERVE on the edge after the start/serve edge is detected. That is 2 slw_clk edges after the button rises: one for edge detection, one for the transition.
- Scores and win flags update on the same edge as the state change.
- If a hit edge and the resolving tick occur in the same cycle, it counts as a hit.
- Asserting `Rst` mid-rally forces the reset values immediately. Asserting `abort` does the same synchronously.

## Structure
- Shared package `pong_pkg`:
  - state enum (IDLE, SERVE, MOVE_DN, MOVE_UP, P1_WIN, P2_WIN);
  - mode encodings MODE_CPU = 0, MODE_2P = 1.
- One sub-module `pong_step_timer`: period register, down-saturating speed-up logic and tick generation. Inputs are `restart`, `hit` and `reload`; outputs are `tick` and `period`.
- Edge detectors and the FSM are implemented in this block.

## Test plan
- Defaults, mode 0, `start_btn` pulse: the ball goes 1000→0100→0010→0001→0010→0100→1000, one step every 4 cycles.
- Mode 0, p1 hit on every MSB dwell: `score_p1` counts 1…10. `p1_win` = 1 on the 10th hit. `colour_leds` then alternates 111/000 every cycle.
- Mode 0, no press at MSB: `p2_win` = 1 and `leds` alternates 1111/0000. An `abort` pulse then returns to IDLE with scores at 0 and `leds` = 1000.
- Speed-up, START_PERIOD = 4, SPEEDUP_HITS = 3: the step interval becomes 3 after 3 hits, 2 after 6, and stays at 1 from 9 onwards.
- Mode 1, P2 misses: `score_p1` = 1, SERVE with `leds` = 0001 and `period` = 4. A p2 edge serves the ball upward. A p1 edge while the ball is mid-track does not latch a hit.
- Early button edge, hit edge coincident with the tick, and `Rst` mid-rally: early edge ignored, coincident edge counts as a hit, `Rst` forces all outputs to zero immediately.
